// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and a
// constant-evaluable ceil(log2) helper for sizing pointers and counters.
package mips_pkg;

    localparam logic ARB_ARB    = 1'b0;
    localparam logic ARB_LOCKED = 1'b1;

    typedef enum logic {
        ST_ARB    = ARB_ARB,
        ST_LOCKED = ARB_LOCKED
    } arb_state_e;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Round-robin find-first: scans req_i starting at ptr_i (wrapping) and
// returns the first hit as a one-hot grant plus its binary index.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin
        int c;
        logic [PW-1:0] ci;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            c = int'(ptr_i) + i;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            ci = PW'(c);
            if (!any_o && req_i[ci]) begin
                any_o     = 1'b1;
                gnt_o[ci] = 1'b1;
                idx_o     = ci;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NREQ cores,
// with a bounded lock for back-to-back atomic read-modify-write sequences.
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ-1:0]    req_we_i,
    input  logic [NREQ-1:0]    req_lock_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_wd_i,
    output logic [NREQ-1:0]    req_gnt_o,
    output logic [NREQ-1:0]    req_stall_o,
    output logic [NREQ-1:0]    rsp_valid_o,
    output logic [DW-1:0]      rsp_rd_o,
    output logic               mem_en_o,
    output logic               mem_we_o,
    output logic [AW-1:0]      mem_addr_o,
    output logic [DW-1:0]      mem_wd_o,
    input  logic [DW-1:0]      mem_rd_i,
    output logic               lock_abort_o
);

    localparam int PW = (NREQ > 1) ? clog2(NREQ) : 1;
    localparam int LW = clog2(LOCK_MAX + 1);

    arb_state_e      state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] k);
        return (int'(k) == NREQ - 1) ? '0 : k + 1'b1;
    endfunction

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_ARB;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            lock_cnt_q  <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // A dropped lock falls through to a normal arbitration in the same cycle.
    always_comb begin
        logic do_arb;
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        lock_cnt_d   = lock_cnt_q;
        req_gnt_o    = '0;
        lock_abort_o = 1'b0;
        do_arb       = 1'b0;
        case (state_q)
            ST_LOCKED: begin
                if (!req_lock_i[owner_q]) begin
                    state_d    = ST_ARB;
                    lock_cnt_d = '0;
                    do_arb     = 1'b1;
                end else if (lock_cnt_q >= LW'(LOCK_MAX)) begin
                    lock_abort_o = 1'b1;
                    state_d      = ST_ARB;
                    lock_cnt_d   = '0;
                    rr_ptr_d     = nxt(owner_q);
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                    if (req_valid_i[owner_q]) begin
                        req_gnt_o = NREQ'(1) << owner_q;
                    end
                end
            end
            default: do_arb = 1'b1;
        endcase
        if (do_arb && pick_any) begin
            req_gnt_o = pick_gnt;
            rr_ptr_d  = nxt(pick_idx);
            if (req_lock_i[pick_idx]) begin
                state_d    = ST_LOCKED;
                owner_d    = pick_idx;
                lock_cnt_d = LW'(1);
            end
        end
    end

    logic [NREQ-1:0][AW-1:0] addr_m;
    logic [NREQ-1:0][DW-1:0] wd_m;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_mux
            assign addr_m[gi] = req_gnt_o[gi] ? req_addr_i[gi*AW +: AW] : '0;
            assign wd_m[gi]   = req_gnt_o[gi] ? req_wd_i[gi*DW +: DW]   : '0;
        end
    endgenerate

    always_comb begin
        mem_addr_o = '0;
        mem_wd_o   = '0;
        for (int i = 0; i < NREQ; i++) begin
            mem_addr_o = mem_addr_o | addr_m[i];
            mem_wd_o   = mem_wd_o | wd_m[i];
        end
    end

    assign mem_en_o    = |req_gnt_o;
    assign mem_we_o    = |(req_gnt_o & req_we_i);
    assign req_stall_o = req_valid_i & ~req_gnt_o;
    assign rsp_valid_d = req_gnt_o & ~req_we_i;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rd_o    = mem_rd_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with two requesters and a short lock limit.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  valid = '0, we = '0, lock = '0;
    logic [63:0] addr = '0, wd = '0;
    logic [31:0] mem_rd = '0;
    logic [1:0]  gnt, stall, rsp_valid;
    logic [31:0] rsp_rd, mem_addr, mem_wd;
    logic        mem_en, mem_we, lock_abort;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.NREQ(2), .AW(32), .DW(32), .LOCK_MAX(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (valid),
        .req_we_i     (we),
        .req_lock_i   (lock),
        .req_addr_i   (addr),
        .req_wd_i     (wd),
        .req_gnt_o    (gnt),
        .req_stall_o  (stall),
        .rsp_valid_o  (rsp_valid),
        .rsp_rd_o     (rsp_rd),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wd_o     (mem_wd),
        .mem_rd_i     (mem_rd),
        .lock_abort_o (lock_abort)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [1:0] v, input logic [1:0] w, input logic [1:0] l,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
        valid = v;
        we    = w;
        lock  = l;
        addr  = {a1, a0};
        wd    = {d1, d0};
    endtask

    initial begin
        logic [1:0] exp_gnt;
        logic [1:0] prev;

        // Reset state
        #12;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_abort", 32'(lock_abort), 32'h0);

        // 1: single read by req0
        @(negedge clk);
        rst_n = 1'b1;
        drv(2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0);
        #1;
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_mem_en", 32'(mem_en), 32'h1);
        chk("t1_mem_we", 32'(mem_we), 32'h0);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_stall", 32'(stall), 32'h0);
        chk("t1_rsp_early", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        drv(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        mem_rd = 32'hDEAD;
        #1;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_rd", rsp_rd, 32'hDEAD);
        chk("t1_idle_en", 32'(mem_en), 32'h0);
        chk("t1_idle_addr", mem_addr, 32'h0);

        // 2: both read continuously; pointer now at 1
        prev = 2'b00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drv(2'b11, 2'b00, 2'b00, 32'h100, 32'h200, 32'h0, 32'h0);
            #1;
            exp_gnt = (i % 2 == 0) ? 2'b10 : 2'b01;
            chk($sformatf("t2_gnt_%0d", i), 32'(gnt), 32'(exp_gnt));
            chk($sformatf("t2_stall_%0d", i), 32'(stall), 32'(exp_gnt ^ 2'b11));
            chk($sformatf("t2_addr_%0d", i), mem_addr, (i % 2 == 0) ? 32'h200 : 32'h100);
            chk($sformatf("t2_rsp_%0d", i), 32'(rsp_valid), 32'(prev));
            prev = exp_gnt;
        end

        // 3: req1 writes while req0 reads
        @(negedge clk);
        drv(2'b11, 2'b10, 2'b00, 32'h30, 32'h20, 32'h77, 32'h55);
        #1;
        chk("t3_gnt_w", 32'(gnt), 32'h2);
        chk("t3_we_w", 32'(mem_we), 32'h1);
        chk("t3_addr_w", mem_addr, 32'h20);
        chk("t3_wd_w", mem_wd, 32'h55);
        chk("t3_rsp_prev", 32'(rsp_valid), 32'h1);
        @(negedge clk);
        drv(2'b01, 2'b00, 2'b00, 32'h30, 32'h20, 32'h77, 32'h55);
        #1;
        chk("t3_gnt_r", 32'(gnt), 32'h1);
        chk("t3_we_r", 32'(mem_we), 32'h0);
        chk("t3_addr_r", mem_addr, 32'h30);
        chk("t3_wd_r", mem_wd, 32'h77);
        chk("t3_no_wr_rsp", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        drv(2'b10, 2'b00, 2'b00, 32'h0, 32'h24, 32'h0, 32'h0);
        #1;
        chk("t3_rsp_r", 32'(rsp_valid), 32'h1);
        chk("t3_gnt_r1", 32'(gnt), 32'h2);

        // 4: req0 locks for 3 cycles while req1 waits; pointer now at 0
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drv(2'b11, 2'b00, 2'b01, 32'h40, 32'h44, 32'h0, 32'h0);
            #1;
            chk($sformatf("t4_gnt_%0d", i), 32'(gnt), 32'h1);
            chk($sformatf("t4_stall_%0d", i), 32'(stall), 32'h2);
            chk($sformatf("t4_abort_%0d", i), 32'(lock_abort), 32'h0);
        end
        @(negedge clk);
        drv(2'b11, 2'b00, 2'b00, 32'h40, 32'h44, 32'h0, 32'h0);
        #1;
        chk("t4_release_gnt", 32'(gnt), 32'h2);
        chk("t4_release_stall", 32'(stall), 32'h1);
        @(negedge clk);
        drv(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("t4_rsp", 32'(rsp_valid), 32'h2);

        // 5: req0 holds the lock past LOCK_MAX=4; pointer at 0
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drv(2'b11, 2'b00, 2'b01, 32'h50, 32'h54, 32'h0, 32'h0);
            #1;
            chk($sformatf("t5_gnt_%0d", i), 32'(gnt), 32'h1);
            chk($sformatf("t5_abort_%0d", i), 32'(lock_abort), 32'h0);
        end
        @(negedge clk);
        #1;
        chk("t5_abort", 32'(lock_abort), 32'h1);
        chk("t5_abort_gnt", 32'(gnt), 32'h0);
        chk("t5_abort_stall", 32'(stall), 32'h3);
        chk("t5_abort_en", 32'(mem_en), 32'h0);
        @(negedge clk);
        #1;
        chk("t5_after_gnt", 32'(gnt), 32'h2);
        chk("t5_after_abort", 32'(lock_abort), 32'h0);

        // 6: reset half a cycle after a captured read grant; pointer at 0
        @(negedge clk);
        drv(2'b01, 2'b00, 2'b00, 32'h60, 32'h0, 32'h0, 32'h0);
        #1;
        chk("t6_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        drv(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("t6_rsp_dropped", 32'(rsp_valid), 32'h0);
        chk("t6_rst_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        #1;
        chk("t6_rsp_held", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drv(2'b11, 2'b00, 2'b00, 32'h70, 32'h74, 32'h0, 32'h0);
        #1;
        chk("t6_first_gnt", 32'(gnt), 32'h1);
        chk("t6_first_addr", mem_addr, 32'h70);
        chk("t6_rsp_none", 32'(rsp_valid), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
